dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the CPU MEM stage (normal priority owner) and an external loader/debug master that issues short bursts.
- Sits between the EX/MEM pipeline register outputs and the datamem instance.
- Stalls the pipeline while the loader owns the port.
- Guarantees loader forward progress with a starvation counter.

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/burst_addr_gen.sv | 45 ++++
 rtl/dmem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module  : dmem_arb_pkg
// Brief   : Shared types and constants for the data-memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [0:0] {
        S_CPU = 1'b0,
        S_LD  = 1'b1
    } arb_state_t;

    localparam logic [3:0] XFER_B = 4'd1;
    localparam logic [3:0] XFER_H = 4'd2;
    localparam logic [3:0] XFER_W = 4'd4;
    localparam logic [3:0] XFER_D = 4'd8;

    localparam int DEFAULT_STARVE_LIMIT = 4;
    localparam int DEFAULT_BURST_MAX    = 4;

endpackage

`default_nettype wire

// File: rtl/burst_addr_gen.sv
// ============================================================================
// Module  : burst_addr_gen
// Brief   : Loader burst address accumulator and beat counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_addr_gen #(
    parameter int DATA_W = 64,
    parameter int LEN_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] base,
    input  logic [3:0]        step,
    input  logic [LEN_W-1:0]  len,
    output logic [DATA_W-1:0] addr,
    output logic              last
);

    logic [DATA_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_beat_cnt;

    // Address wraps modulo 2^DATA_W by plain unsigned overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_beat_cnt <= '0;
        end else if (load) begin
            r_addr     <= base;
            r_beat_cnt <= '0;
        end else if (advance) begin
            r_addr     <= r_addr + DATA_W'(step);
            r_beat_cnt <= r_beat_cnt + LEN_W'(1);
        end
    end

    assign addr = r_addr;
    assign last = (r_beat_cnt == len);

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module  : dmem_port_arbiter
// Brief   : Shares the data-memory port between the CPU MEM stage and a
//           burst loader, with starvation-bounded loader grants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter  int DATA_W       = 64,
    parameter  int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter  int BURST_MAX    = DEFAULT_BURST_MAX,
    localparam int LEN_W        = $clog2(BURST_MAX)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [3:0]        cpu_xfer,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_wr,
    input  logic [DATA_W-1:0] ld_addr,
    input  logic [3:0]        ld_xfer,
    input  logic [LEN_W-1:0]  ld_len,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              ld_done,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [3:0]        mem_xfer,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              SC_W         = $clog2(STARVE_LIMIT) + 1;
    localparam logic [SC_W-1:0] C_STARVE_MAX = SC_W'(STARVE_LIMIT - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [SC_W-1:0]   r_starve_cnt;
    logic [SC_W-1:0]   w_starve_nxt;
    logic              r_wr;
    logic [3:0]        r_xfer;
    logic [LEN_W-1:0]  r_len;
    logic [DATA_W-1:0] r_ld_rdata;
    logic              r_ld_rvalid;
    logic              w_grant;
    logic              w_beat;
    logic              w_last;
    logic [DATA_W-1:0] w_burst_addr;

    assign w_grant = (r_state == S_CPU) && ld_req &&
                     (!cpu_req || (r_starve_cnt == C_STARVE_MAX));
    // A reset cycle already counts as aborted: no beat, no done pulse.
    assign w_beat  = (r_state == S_LD) && !reset;

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        case (r_state)
            S_CPU: begin
                if (!ld_req) begin
                    w_starve_nxt = '0;
                end else if (w_grant) begin
                    w_state_nxt  = S_LD;
                    w_starve_nxt = '0;
                end else begin
                    w_starve_nxt = r_starve_cnt + SC_W'(1);
                end
            end
            S_LD: begin
                if (w_last) begin
                    w_state_nxt = S_CPU;
                end
            end
            default: w_state_nxt = S_CPU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_CPU;
            r_starve_cnt <= '0;
            r_wr         <= 1'b0;
            r_xfer       <= XFER_B;
            r_len        <= '0;
            r_ld_rdata   <= '0;
            r_ld_rvalid  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            if (w_grant) begin
                r_wr   <= ld_wr;
                r_xfer <= ld_xfer;
                r_len  <= ld_len;
            end
            r_ld_rvalid <= w_beat && !r_wr;
            if (w_beat && !r_wr) begin
                r_ld_rdata <= mem_rdata;
            end
        end
    end

    burst_addr_gen #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (reset),
        .load    (w_grant),
        .advance (w_beat),
        .base    (ld_addr),
        .step    (r_xfer),
        .len     (r_len),
        .addr    (w_burst_addr),
        .last    (w_last)
    );

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_xfer  = cpu_xfer;
        mem_wr_en = cpu_req && cpu_wr;
        mem_rd_en = cpu_req && !cpu_wr;
        if (r_state == S_LD) begin
            mem_addr  = w_burst_addr;
            mem_wdata = ld_wdata;
            mem_xfer  = r_xfer;
            mem_wr_en = w_beat && r_wr;
            mem_rd_en = w_beat && !r_wr;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign cpu_stall = w_beat && cpu_req;
    assign ld_gnt    = w_beat;
    assign ld_done   = w_beat && w_last;
    assign ld_rdata  = r_ld_rdata;
    assign ld_rvalid = r_ld_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// Module  : tb_dmem_port_arbiter
// Brief   : Directed, table-driven checks of dmem_port_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

    localparam logic [63:0] K_MEM      = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] CPU_WDATA  = 64'h0000_0000_00C0_FFEE;
    localparam logic [3:0]  CPU_XFER   = 4'd4;
    localparam int          NVEC       = 19;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_wr;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_xfer;
    logic        cpu_stall;
    logic        ld_req, ld_wr;
    logic [63:0] ld_addr, ld_wdata, ld_rdata;
    logic [3:0]  ld_xfer;
    logic [1:0]  ld_len;
    logic        ld_gnt, ld_rvalid, ld_done;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr_en, mem_rd_en;
    logic [3:0]  mem_xfer;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Memory model: combinational read derived from the address.
    assign mem_rdata = mem_addr ^ K_MEM;

    dmem_port_arbiter #(
        .DATA_W       (64),
        .STARVE_LIMIT (4),
        .BURST_MAX    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_xfer  (cpu_xfer),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ld_req    (ld_req),
        .ld_wr     (ld_wr),
        .ld_addr   (ld_addr),
        .ld_xfer   (ld_xfer),
        .ld_len    (ld_len),
        .ld_wdata  (ld_wdata),
        .ld_gnt    (ld_gnt),
        .ld_rdata  (ld_rdata),
        .ld_rvalid (ld_rvalid),
        .ld_done   (ld_done),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_xfer  (mem_xfer),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic        rst;
        logic        creq;
        logic        cwr;
        logic [63:0] caddr;
        logic        lreq;
        logic        lwr;
        logic [63:0] laddr;
        logic [3:0]  lxfer;
        logic [1:0]  llen;
        logic        e_stall;
        logic        e_gnt;
        logic        e_done;
        logic        e_rv;
        logic        e_wr;
        logic        e_rd;
        logic [63:0] e_addr;
        logic [63:0] e_rdata;
        logic [3:0]  e_xfer;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mk(
        input logic rst, input logic creq, input logic cwr, input logic [63:0] caddr,
        input logic lreq, input logic lwr, input logic [63:0] laddr,
        input logic [3:0] lxfer, input logic [1:0] llen,
        input logic e_stall, input logic e_gnt, input logic e_done, input logic e_rv,
        input logic e_wr, input logic e_rd, input logic [63:0] e_addr,
        input logic [63:0] e_rdata, input logic [3:0] e_xfer);
        vec_t v;
        v.rst = rst;   v.creq = creq;   v.cwr = cwr;   v.caddr = caddr;
        v.lreq = lreq; v.lwr = lwr;     v.laddr = laddr;
        v.lxfer = lxfer; v.llen = llen;
        v.e_stall = e_stall; v.e_gnt = e_gnt; v.e_done = e_done; v.e_rv = e_rv;
        v.e_wr = e_wr; v.e_rd = e_rd; v.e_addr = e_addr;
        v.e_rdata = e_rdata; v.e_xfer = e_xfer;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk(input string tag, input logic e_stall, input logic e_gnt,
                       input logic e_done, input logic e_wr, input logic e_rd,
                       input logic [63:0] e_addr);
        cmp({tag, ".cpu_stall"}, 64'(cpu_stall), 64'(e_stall));
        cmp({tag, ".ld_gnt"},    64'(ld_gnt),    64'(e_gnt));
        cmp({tag, ".ld_done"},   64'(ld_done),   64'(e_done));
        cmp({tag, ".mem_wr_en"}, 64'(mem_wr_en), 64'(e_wr));
        cmp({tag, ".mem_rd_en"}, 64'(mem_rd_en), 64'(e_rd));
        if (e_wr || e_rd) cmp({tag, ".mem_addr"}, mem_addr, e_addr);
    endtask

    task automatic drive(input logic creq, input logic cwr, input logic [63:0] caddr,
                         input logic lreq, input logic lwr, input logic [63:0] laddr,
                         input logic [3:0] lxfer, input logic [1:0] llen);
        cpu_req = creq; cpu_wr = cwr; cpu_addr = caddr;
        ld_req = lreq;  ld_wr = lwr;  ld_addr = laddr;
        ld_xfer = lxfer; ld_len = llen;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst creq cwr caddr | lreq lwr laddr xfer len | stall gnt done rv wr rd addr rdata xfer
        tbl[0]  = mk(1,0,0,64'h0,   0,0,64'h0,4'd8,2'd0,  0,0,0,0,0,0,64'h0,64'h0,CPU_XFER);
        tbl[1]  = mk(0,1,0,64'h10,  0,0,64'h0,4'd8,2'd0,  0,0,0,0,0,1,64'h10,64'h0,CPU_XFER);
        tbl[2]  = mk(0,1,0,64'h10,  0,0,64'h0,4'd8,2'd0,  0,0,0,0,0,1,64'h10,64'h0,CPU_XFER);
        tbl[3]  = mk(0,1,1,64'h20,  0,0,64'h0,4'd8,2'd0,  0,0,0,0,1,0,64'h20,64'h0,CPU_XFER);
        tbl[4]  = mk(0,0,0,64'h0,   1,1,64'h100,4'd8,2'd3, 0,0,0,0,0,0,64'h0,64'h0,CPU_XFER);
        tbl[5]  = mk(0,0,0,64'h0,   0,0,64'hDEAD0,4'd2,2'd0, 0,1,0,0,1,0,64'h100,64'h0,4'd8);
        tbl[6]  = mk(0,1,0,64'h40,  0,0,64'hDEAD0,4'd2,2'd0, 1,1,0,0,1,0,64'h108,64'h0,4'd8);
        tbl[7]  = mk(0,0,0,64'h0,   0,0,64'hDEAD0,4'd2,2'd0, 0,1,0,0,1,0,64'h110,64'h0,4'd8);
        tbl[8]  = mk(0,0,0,64'h0,   0,0,64'hDEAD0,4'd2,2'd0, 0,1,1,0,1,0,64'h118,64'h0,4'd8);
        tbl[9]  = mk(0,0,0,64'h0,   0,0,64'h0,4'd8,2'd0,  0,0,0,0,0,0,64'h0,64'h0,CPU_XFER);
        tbl[10] = mk(0,0,0,64'h0,   1,0,64'h200,4'd4,2'd1, 0,0,0,0,0,0,64'h0,64'h0,CPU_XFER);
        tbl[11] = mk(0,0,0,64'h0,   0,0,64'h0,4'd8,2'd0,  0,1,0,0,0,1,64'h200,64'h0,4'd4);
        tbl[12] = mk(0,0,0,64'h0,   0,0,64'h0,4'd8,2'd0,  0,1,1,1,0,1,64'h204,64'h200 ^ K_MEM,4'd4);
        tbl[13] = mk(0,0,0,64'h0,   0,0,64'h0,4'd8,2'd0,  0,0,0,1,0,0,64'h0,64'h204 ^ K_MEM,CPU_XFER);
        tbl[14] = mk(0,0,0,64'h0,   0,0,64'h0,4'd8,2'd0,  0,0,0,0,0,0,64'h0,64'h0,CPU_XFER);
        tbl[15] = mk(0,0,0,64'h0,   1,1,64'hFFFF_FFFF_FFFF_FFF8,4'd8,2'd1, 0,0,0,0,0,0,64'h0,64'h0,CPU_XFER);
        tbl[16] = mk(0,0,0,64'h0,   0,0,64'h0,4'd8,2'd0,  0,1,0,0,1,0,64'hFFFF_FFFF_FFFF_FFF8,64'h0,4'd8);
        tbl[17] = mk(0,0,0,64'h0,   0,0,64'h0,4'd8,2'd0,  0,1,1,0,1,0,64'h0,64'h0,4'd8);
        tbl[18] = mk(0,0,0,64'h0,   0,0,64'h0,4'd8,2'd0,  0,0,0,0,0,0,64'h0,64'h0,CPU_XFER);

        reset     = 1'b1;
        cpu_wdata = CPU_WDATA;
        cpu_xfer  = CPU_XFER;
        ld_wdata  = '0;
        drive(0, 0, 64'h0, 0, 0, 64'h0, 4'd8, 2'd0);
        next_cycle();
        next_cycle();

        for (int i = 0; i < NVEC; i++) begin
            reset    = tbl[i].rst;
            ld_wdata = 64'h5000 + 64'(i);
            drive(tbl[i].creq, tbl[i].cwr, tbl[i].caddr, tbl[i].lreq, tbl[i].lwr,
                  tbl[i].laddr, tbl[i].lxfer, tbl[i].llen);
            #4;
            chk($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_gnt, tbl[i].e_done,
                tbl[i].e_wr, tbl[i].e_rd, tbl[i].e_addr);
            cmp($sformatf("vec%0d.ld_rvalid", i), 64'(ld_rvalid), 64'(tbl[i].e_rv));
            cmp($sformatf("vec%0d.mem_xfer", i), 64'(mem_xfer), 64'(tbl[i].e_xfer));
            cmp($sformatf("vec%0d.cpu_rdata", i), cpu_rdata, mem_addr ^ K_MEM);
            if (tbl[i].e_rv || tbl[i].rst)
                cmp($sformatf("vec%0d.ld_rdata", i), ld_rdata, tbl[i].e_rdata);
            if (tbl[i].e_wr)
                cmp($sformatf("vec%0d.mem_wdata", i), mem_wdata,
                    tbl[i].e_gnt ? (64'h5000 + 64'(i)) : CPU_WDATA);
            next_cycle();
        end

        // Starvation: CPU holds the port for STARVE_LIMIT cycles, loader then wins.
        drive(1, 0, 64'h40, 1, 1, 64'h300, 4'd2, 2'd1);
        for (int i = 0; i < 6; i++) begin
            #4;
            if (i < 4) chk($sformatf("starve%0d", i), 0, 0, 0, 0, 1, 64'h40);
            else       chk($sformatf("starve%0d", i), 1, 1, i == 5, 1, 0,
                           64'h300 + 64'(2 * (i - 4)));
            next_cycle();
        end

        // Back-to-back with CPU still contending: starvation window restarts.
        drive(1, 0, 64'h40, 1, 1, 64'h400, 4'd8, 2'd0);
        for (int i = 0; i < 5; i++) begin
            #4;
            if (i < 4) chk($sformatf("b2b_busy%0d", i), 0, 0, 0, 0, 1, 64'h40);
            else       chk("b2b_busy_beat", 1, 1, 1, 1, 0, 64'h400);
            next_cycle();
        end

        // Back-to-back with the CPU idle: exactly one S_CPU cycle between bursts.
        drive(0, 0, 64'h0, 1, 1, 64'h480, 4'd8, 2'd0);
        #4;
        chk("b2b_gap", 0, 0, 0, 0, 0, 64'h0);
        next_cycle();
        drive(0, 0, 64'h0, 0, 0, 64'h0, 4'd8, 2'd0);
        #4;
        chk("b2b_beat", 0, 1, 1, 1, 0, 64'h480);
        next_cycle();
        #4;
        chk("b2b_after", 0, 0, 0, 0, 0, 64'h0);
        next_cycle();

        // Reset in the middle of a 4-beat read burst.
        drive(0, 0, 64'h0, 1, 0, 64'h500, 4'd8, 2'd3);
        #4;
        chk("rst_dec", 0, 0, 0, 0, 0, 64'h0);
        next_cycle();
        drive(0, 0, 64'h0, 0, 0, 64'h0, 4'd8, 2'd0);
        #4;
        chk("rst_beat0", 0, 1, 0, 0, 1, 64'h500);
        next_cycle();
        reset = 1'b1;
        #4;
        cmp("rst_cyc.ld_rvalid", 64'(ld_rvalid), 64'd1);
        cmp("rst_cyc.ld_rdata", ld_rdata, 64'h500 ^ K_MEM);
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4;
            chk($sformatf("rst_after%0d", i), 0, 0, 0, 0, 0, 64'h0);
            cmp($sformatf("rst_after%0d.ld_rvalid", i), 64'(ld_rvalid), 64'd0);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
